// File: rtl/atm_pkg.sv
// Shared encodings for the ATM session controller and the display side.
// Holds the FSM state type, request op codes and response status codes,
// plus a small helper that tells whether an op code is a defined operation.
package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AUTH = 3'd1,
    ST_MENU = 3'd2,
    ST_EXEC = 3'd3
  } state_e;

  localparam logic [2:0] OP_LOGIN      = 3'd0;
  localparam logic [2:0] OP_BALANCE    = 3'd1;
  localparam logic [2:0] OP_WITHDRAW   = 3'd2;
  localparam logic [2:0] OP_DEPOSIT    = 3'd3;
  localparam logic [2:0] OP_CHANGE_PIN = 3'd4;
  localparam logic [2:0] OP_EXIT       = 3'd5;

  localparam logic [2:0] RSP_OK      = 3'd0;
  localparam logic [2:0] RSP_PIN     = 3'd1;
  localparam logic [2:0] RSP_LOCKED  = 3'd2;
  localparam logic [2:0] RSP_NO_ACC  = 3'd3;
  localparam logic [2:0] RSP_FUNDS   = 3'd4;
  localparam logic [2:0] RSP_AMOUNT  = 3'd5;
  localparam logic [2:0] RSP_SEQ     = 3'd6;
  localparam logic [2:0] RSP_TIMEOUT = 3'd7;

  // Op codes 6 and 7 are reserved and answered with RSP_SEQ.
  function automatic logic op_defined(input logic [2:0] op_code);
    return (op_code <= OP_EXIT);
  endfunction

endpackage

// File: rtl/atm_account_store.sv
// Per-account register file: balance, PIN, lock bit and consecutive-fail counter.
// One combinational read port and one synchronous write port (all fields of one
// account written together). Out-of-range indices read as zero and ignore writes.
// Ports:
//   clk, rst_n        clock, async active-low reset (restores initial contents)
//   rd_idx            read account index; rd_bal/rd_pin/rd_lock/rd_fail read data
//   wr_en, wr_idx     write strobe and account index
//   wr_bal/wr_pin/wr_lock/wr_fail  write data
module atm_account_store
  import atm_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 10,
  parameter int ACC_W        = 4,
  parameter int BAL_W        = 16,
  parameter int PIN_W        = 16,
  parameter int FAIL_W       = 2,
  parameter int INIT_BALANCE = 500,
  parameter int INIT_PIN     = 1234
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ACC_W-1:0]  rd_idx,
  output logic [BAL_W-1:0]  rd_bal,
  output logic [PIN_W-1:0]  rd_pin,
  output logic              rd_lock,
  output logic [FAIL_W-1:0] rd_fail,
  input  logic              wr_en,
  input  logic [ACC_W-1:0]  wr_idx,
  input  logic [BAL_W-1:0]  wr_bal,
  input  logic [PIN_W-1:0]  wr_pin,
  input  logic              wr_lock,
  input  logic [FAIL_W-1:0] wr_fail
);

  localparam logic [BAL_W-1:0] INIT_BAL_L = BAL_W'(INIT_BALANCE);
  localparam logic [PIN_W-1:0] INIT_PIN_L = PIN_W'(INIT_PIN);

  logic [BAL_W-1:0]  bal_r  [NUM_ACCOUNTS];
  logic [PIN_W-1:0]  pin_r  [NUM_ACCOUNTS];
  logic              lock_r [NUM_ACCOUNTS];
  logic [FAIL_W-1:0] fail_r [NUM_ACCOUNTS];

  logic rd_ok_s;
  logic wr_ok_s;

  assign rd_ok_s = (int'(rd_idx) < NUM_ACCOUNTS);
  assign wr_ok_s = (int'(wr_idx) < NUM_ACCOUNTS);

  // Read mux; an invalid index returns an all-zero record.
  always_comb begin
    rd_bal  = {BAL_W{1'b0}};
    rd_pin  = {PIN_W{1'b0}};
    rd_lock = 1'b0;
    rd_fail = {FAIL_W{1'b0}};
    if (rd_ok_s) begin
      rd_bal  = bal_r[rd_idx];
      rd_pin  = pin_r[rd_idx];
      rd_lock = lock_r[rd_idx];
      rd_fail = fail_r[rd_idx];
    end else begin
      rd_bal  = {BAL_W{1'b0}};
    end
  end

  // Storage registers; reset restores every account to its initial record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        bal_r[i]  <= INIT_BAL_L;
        pin_r[i]  <= INIT_PIN_L;
        lock_r[i] <= 1'b0;
        fail_r[i] <= {FAIL_W{1'b0}};
      end
    end else if (wr_en && wr_ok_s) begin
      bal_r[wr_idx]  <= wr_bal;
      pin_r[wr_idx]  <= wr_pin;
      lock_r[wr_idx] <= wr_lock;
      fail_r[wr_idx] <= wr_fail;
    end
  end

endmodule

// File: rtl/atm_session_controller.sv
// ATM session controller: login FSM with PIN retry lockout, one operation per
// accepted request, session timeout and card-removal handling.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   card_in      card present level
//   req_valid/req_ready  request handshake; op, acc_num, pin, amount request payload
//   rsp_valid    one-cycle response pulse with rsp_status and balance
//   state        current FSM state (IDLE/AUTH/MENU/EXEC)
// Timing: a request accepted at cycle N moves to AUTH/EXEC at N+1 and the
// response appears at N+2 together with the follow-on state. Sequencing
// errors (SEQ) are answered one cycle after acceptance without leaving state.
module atm_session_controller
  import atm_pkg::*;
#(
  parameter int NUM_ACCOUNTS   = 10,
  parameter int BAL_W          = 16,
  parameter int PIN_W          = 16,
  parameter int INIT_BALANCE   = 500,
  parameter int INIT_PIN       = 1234,
  parameter int MAX_PIN_TRIES  = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int ACC_W          = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             card_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       op,
  input  logic [ACC_W-1:0] acc_num,
  input  logic [PIN_W-1:0] pin,
  input  logic [BAL_W-1:0] amount,
  output logic             rsp_valid,
  output logic [2:0]       rsp_status,
  output logic [BAL_W-1:0] balance,
  output logic [2:0]       state
);

  localparam int FAIL_W = $clog2(MAX_PIN_TRIES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FAIL_W-1:0] MAX_FAIL_L = FAIL_W'(MAX_PIN_TRIES);
  localparam logic [TMO_W-1:0]  TMO_LAST_L = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e            state_r;
  logic              rdy_en_r;
  logic              rsp_valid_r;
  logic [2:0]        rsp_status_r;
  logic [BAL_W-1:0]  balance_r;
  logic [ACC_W-1:0]  acc_r;
  logic [2:0]        op_r;
  logic [PIN_W-1:0]  pin_r;
  logic [BAL_W-1:0]  amt_r;
  logic [TMO_W-1:0]  tmo_r;

  logic              accept_s;
  logic              acc_ok_s;
  logic [BAL_W-1:0]  st_bal_s;
  logic [PIN_W-1:0]  st_pin_s;
  logic              st_lock_s;
  logic [FAIL_W-1:0] st_fail_s;
  logic              wr_en_s;
  logic [BAL_W-1:0]  wr_bal_s;
  logic [PIN_W-1:0]  wr_pin_s;
  logic              wr_lock_s;
  logic [FAIL_W-1:0] wr_fail_s;
  logic [2:0]        res_status_s;
  logic [BAL_W-1:0]  res_bal_s;
  logic [BAL_W:0]    sum_s;

  // rdy_en_r keeps req_ready low while reset is applied, whatever card_in does.
  assign req_ready  = rdy_en_r && ((state_r == ST_IDLE && card_in) || state_r == ST_MENU);
  assign accept_s   = req_valid && req_ready;
  assign acc_ok_s   = (int'(acc_r) < NUM_ACCOUNTS);
  assign sum_s      = {1'b0, st_bal_s} + {1'b0, amt_r};
  assign rsp_valid  = rsp_valid_r;
  assign rsp_status = rsp_status_r;
  assign balance    = balance_r;
  assign state      = state_r;

  atm_account_store #(
    .NUM_ACCOUNTS (NUM_ACCOUNTS),
    .ACC_W        (ACC_W),
    .BAL_W        (BAL_W),
    .PIN_W        (PIN_W),
    .FAIL_W       (FAIL_W),
    .INIT_BALANCE (INIT_BALANCE),
    .INIT_PIN     (INIT_PIN)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (acc_r),
    .rd_bal  (st_bal_s),
    .rd_pin  (st_pin_s),
    .rd_lock (st_lock_s),
    .rd_fail (st_fail_s),
    .wr_en   (wr_en_s),
    .wr_idx  (acc_r),
    .wr_bal  (wr_bal_s),
    .wr_pin  (wr_pin_s),
    .wr_lock (wr_lock_s),
    .wr_fail (wr_fail_s)
  );

  // Result of the AUTH / EXEC cycle and the matching store write-back.
  always_comb begin
    wr_en_s      = 1'b0;
    wr_bal_s     = st_bal_s;
    wr_pin_s     = st_pin_s;
    wr_lock_s    = st_lock_s;
    wr_fail_s    = st_fail_s;
    res_status_s = RSP_SEQ;
    res_bal_s    = st_bal_s;
    case (state_r)
      ST_AUTH: begin
        if (!acc_ok_s) begin
          res_status_s = RSP_NO_ACC;
        end else if (st_lock_s) begin
          // Locked accounts leave the fail counter untouched.
          res_status_s = RSP_LOCKED;
        end else if (pin_r != st_pin_s) begin
          res_status_s = RSP_PIN;
          wr_en_s      = 1'b1;
          wr_fail_s    = st_fail_s + FAIL_W'(1);
          wr_lock_s    = (wr_fail_s == MAX_FAIL_L);
        end else begin
          res_status_s = RSP_OK;
          wr_en_s      = 1'b1;
          wr_fail_s    = {FAIL_W{1'b0}};
        end
      end
      ST_EXEC: begin
        case (op_r)
          OP_BALANCE: res_status_s = RSP_OK;
          OP_WITHDRAW: begin
            if (amt_r == {BAL_W{1'b0}}) begin
              res_status_s = RSP_AMOUNT;
            end else if (amt_r > st_bal_s) begin
              res_status_s = RSP_FUNDS;
            end else begin
              res_status_s = RSP_OK;
              wr_en_s      = 1'b1;
              wr_bal_s     = st_bal_s - amt_r;
              res_bal_s    = wr_bal_s;
            end
          end
          OP_DEPOSIT: begin
            // A carry out of BAL_W means the balance cannot represent the sum.
            if (amt_r == {BAL_W{1'b0}} || sum_s[BAL_W]) begin
              res_status_s = RSP_AMOUNT;
            end else begin
              res_status_s = RSP_OK;
              wr_en_s      = 1'b1;
              wr_bal_s     = sum_s[BAL_W-1:0];
              res_bal_s    = wr_bal_s;
            end
          end
          OP_CHANGE_PIN: begin
            res_status_s = RSP_OK;
            wr_en_s      = 1'b1;
            wr_pin_s     = pin_r;
          end
          OP_EXIT: res_status_s = RSP_OK;
          default: res_status_s = RSP_SEQ;
        endcase
      end
      default: res_status_s = RSP_SEQ;
    endcase
  end

  // Session FSM with registered response, balance and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      rdy_en_r     <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_status_r <= 3'd0;
      balance_r    <= {BAL_W{1'b0}};
      acc_r        <= {ACC_W{1'b0}};
      op_r         <= 3'd0;
      pin_r        <= {PIN_W{1'b0}};
      amt_r        <= {BAL_W{1'b0}};
      tmo_r        <= {TMO_W{1'b0}};
    end else begin
      rdy_en_r    <= 1'b1;
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          tmo_r     <= {TMO_W{1'b0}};
          balance_r <= {BAL_W{1'b0}};
          if (accept_s) begin
            if (op == OP_LOGIN) begin
              acc_r   <= acc_num;
              pin_r   <= pin;
              state_r <= ST_AUTH;
            end else begin
              rsp_valid_r  <= 1'b1;
              rsp_status_r <= RSP_SEQ;
            end
          end
        end
        ST_AUTH: begin
          rsp_valid_r  <= 1'b1;
          rsp_status_r <= res_status_s;
          if (res_status_s == RSP_OK && card_in) begin
            state_r   <= ST_MENU;
            balance_r <= res_bal_s;
          end else begin
            state_r   <= ST_IDLE;
            balance_r <= {BAL_W{1'b0}};
          end
        end
        ST_MENU: begin
          // An accept in the same cycle as timeout expiry wins and clears the counter.
          if (accept_s) begin
            tmo_r <= {TMO_W{1'b0}};
            if (op == OP_LOGIN || !op_defined(op)) begin
              rsp_valid_r  <= 1'b1;
              rsp_status_r <= RSP_SEQ;
            end else begin
              op_r    <= op;
              pin_r   <= pin;
              amt_r   <= amount;
              state_r <= ST_EXEC;
            end
          end else if (!card_in) begin
            state_r   <= ST_IDLE;
            balance_r <= {BAL_W{1'b0}};
            tmo_r     <= {TMO_W{1'b0}};
          end else if (tmo_r == TMO_LAST_L) begin
            rsp_valid_r  <= 1'b1;
            rsp_status_r <= RSP_TIMEOUT;
            state_r      <= ST_IDLE;
            balance_r    <= {BAL_W{1'b0}};
            tmo_r        <= {TMO_W{1'b0}};
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        ST_EXEC: begin
          rsp_valid_r  <= 1'b1;
          rsp_status_r <= res_status_s;
          if (op_r == OP_EXIT || !card_in) begin
            state_r   <= ST_IDLE;
            balance_r <= {BAL_W{1'b0}};
          end else begin
            state_r   <= ST_MENU;
            balance_r <= res_bal_s;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          balance_r <= {BAL_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atm_session_controller.sv
// Scoreboard bench for atm_session_controller: each request pushes its expected
// response (status, balance, follow-on state) and a negedge monitor pops and
// compares whenever rsp_valid pulses.
module tb_atm_session_controller;

  logic        clk;
  logic        rst_n;
  logic        card_in;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic [15:0] amount;
  logic        rsp_valid;
  logic [2:0]  rsp_status;
  logic [15:0] balance;
  logic [2:0]  state;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] bal;
    logic [2:0]  nst;
    logic        gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_rsp_cyc = 0;

  atm_session_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .card_in    (card_in),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .acc_num    (acc_num),
    .pin        (pin),
    .amount     (amount),
    .rsp_valid  (rsp_valid),
    .rsp_status (rsp_status),
    .balance    (balance),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_status), 32'd99);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_status", 32'(rsp_status), 32'(e.st));
        check("rsp_balance", 32'(balance), 32'(e.bal));
        check("rsp_state", 32'(state), 32'(e.nst));
        if (e.gap) check("timeout_gap", 32'(cyc - last_rsp_cyc), 32'd1000);
      end
      last_rsp_cyc = cyc;
    end
  end

  task automatic wait_rsp(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      check("rsp_missing", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // Issue one request (called at posedge+1) and expect one response.
  task automatic req(input logic [2:0] o, input logic [3:0] a, input logic [15:0] p,
                     input logic [15:0] amt, input logic [2:0] est, input logic [15:0] ebal,
                     input logic [2:0] enst, input bit chk_lat);
    int guard = 0;
    exp_t e;
    while (!req_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!req_ready) begin
      check("ready_wait", 32'(req_ready), 32'd1);
    end else begin
      op = o; acc_num = a; pin = p; amount = amt; req_valid = 1'b1;
      e.st = est; e.bal = ebal; e.nst = enst; e.gap = 1'b0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (chk_lat) begin
        check("lat_auth_state", 32'(state), 32'd1);
        check("lat_no_early_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_rsp_valid", 32'(rsp_valid), 32'd1);
      end
      wait_rsp(40);
    end
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; card_in = 1'b1; req_valid = 1'b0;
    op = 3'd0; acc_num = 4'd0; pin = 16'd0; amount = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_balance", 32'(balance), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Login with latency check, then withdraw boundaries.
    req(3'd0, 4'd3, 16'd1234, 16'd0,   3'd0, 16'd500, 3'd2, 1'b1);
    req(3'd2, 4'd0, 16'd0,    16'd200, 3'd0, 16'd300, 3'd2, 1'b0);
    req(3'd2, 4'd0, 16'd0,    16'd301, 3'd4, 16'd300, 3'd2, 1'b0);
    req(3'd2, 4'd0, 16'd0,    16'd300, 3'd0, 16'd0,   3'd2, 1'b0);
    req(3'd2, 4'd0, 16'd0,    16'd0,   3'd5, 16'd0,   3'd2, 1'b0);
    req(3'd1, 4'd0, 16'd0,    16'd0,   3'd0, 16'd0,   3'd2, 1'b0);
    req(3'd5, 4'd0, 16'd0,    16'd0,   3'd0, 16'd0,   3'd0, 1'b0);

    // Deposit boundaries and sequencing errors in MENU.
    req(3'd0, 4'd5, 16'd1234, 16'd0,     3'd0, 16'd500,   3'd2, 1'b0);
    req(3'd3, 4'd0, 16'd0,    16'd65035, 3'd0, 16'd65535, 3'd2, 1'b0);
    req(3'd3, 4'd0, 16'd0,    16'd1,     3'd5, 16'd65535, 3'd2, 1'b0);
    req(3'd3, 4'd0, 16'd0,    16'd0,     3'd5, 16'd65535, 3'd2, 1'b0);
    req(3'd0, 4'd1, 16'd1234, 16'd0,     3'd6, 16'd65535, 3'd2, 1'b0);
    req(3'd6, 4'd0, 16'd0,    16'd0,     3'd6, 16'd65535, 3'd2, 1'b0);
    req(3'd5, 4'd0, 16'd0,    16'd0,     3'd0, 16'd0,     3'd0, 1'b0);
    req(3'd1, 4'd0, 16'd0,    16'd0,     3'd6, 16'd0,     3'd0, 1'b0);

    // PIN lockout on account 2; account 4 unaffected.
    for (int i = 0; i < 3; i++)
      req(3'd0, 4'd2, 16'd1111, 16'd0, 3'd1, 16'd0, 3'd0, 1'b0);
    req(3'd0, 4'd2, 16'd1234, 16'd0, 3'd2, 16'd0,   3'd0, 1'b0);
    req(3'd0, 4'd4, 16'd1234, 16'd0, 3'd0, 16'd500, 3'd2, 1'b0);

    // PIN change.
    req(3'd4, 4'd0, 16'd4321, 16'd0, 3'd0, 16'd500, 3'd2, 1'b0);
    req(3'd5, 4'd0, 16'd0,    16'd0, 3'd0, 16'd0,   3'd0, 1'b0);
    req(3'd0, 4'd4, 16'd1234, 16'd0, 3'd1, 16'd0,   3'd0, 1'b0);
    req(3'd0, 4'd4, 16'd4321, 16'd0, 3'd0, 16'd500, 3'd2, 1'b0);

    // Idle timeout in MENU, exactly 1000 cycles after the login response.
    e.st = 3'd7; e.bal = 16'd0; e.nst = 3'd0; e.gap = 1'b1;
    exp_q.push_back(e);
    wait_rsp(1100);

    // Account 3 keeps its withdrawn balance; then card removal in MENU.
    req(3'd0, 4'd3, 16'd1234, 16'd0, 3'd0, 16'd0, 3'd2, 1'b0);
    card_in = 1'b0;
    @(posedge clk);
    #1;
    check("drop_state", 32'(state), 32'd0);
    check("drop_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("drop_no_rsp", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    card_in = 1'b1;
    req(3'd0, 4'd12, 16'd1234, 16'd0, 3'd3, 16'd0, 3'd0, 1'b0);

    // Reset mid-session restores the store.
    req(3'd0, 4'd4, 16'd4321, 16'd0, 3'd0, 16'd500, 3'd2, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst2_state", 32'(state), 32'd0);
    check("rst2_balance", 32'(balance), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req(3'd0, 4'd3, 16'd1234, 16'd0, 3'd0, 16'd500, 3'd2, 1'b0);
    req(3'd5, 4'd0, 16'd0,    16'd0, 3'd0, 16'd0,   3'd0, 1'b0);
    req(3'd0, 4'd2, 16'd1234, 16'd0, 3'd0, 16'd500, 3'd2, 1'b0);
    req(3'd5, 4'd0, 16'd0,    16'd0, 3'd0, 16'd0,   3'd0, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
